// File: rtl/shared_timer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : shared_timer_arbiter
// Brief    : Round-robin sharing of one down-counter among NREQ requesters.
// Revision : 1.0 - initial release
// ============================================================================
module shared_timer_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] load_val,
    input  logic                  abort,
    output logic [NREQ-1:0]       grant,
    output logic                  busy,
    output logic [WIDTH-1:0]      count,
    output logic [NREQ-1:0]       done
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_count, w_count_nxt;
    logic [NREQ-1:0]  r_grant, w_grant_nxt;
    logic [IW-1:0]    r_owner, w_owner_nxt;
    logic [IW-1:0]    r_ptr,   w_ptr_nxt;
    logic [IW-1:0]    w_pick;
    logic             w_pick_vld;
    logic [WIDTH-1:0] w_load;

    // Two passes: indices at/above the pointer first, then wrap to the bottom.
    always_comb begin
        w_pick     = '0;
        w_pick_vld = 1'b0;
        for (int c = 0; c < NREQ; c++) begin
            if (!w_pick_vld && req[c] && (IW'(c) >= r_ptr)) begin
                w_pick_vld = 1'b1;
                w_pick     = IW'(c);
            end
        end
        for (int c = 0; c < NREQ; c++) begin
            if (!w_pick_vld && req[c]) begin
                w_pick_vld = 1'b1;
                w_pick     = IW'(c);
            end
        end
    end

    always_comb begin
        w_load = '0;
        for (int c = 0; c < NREQ; c++) begin
            if (r_owner == IW'(c)) begin
                w_load = load_val[c*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_grant_nxt = r_grant;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            S_IDLE: begin
                if (w_pick_vld) begin
                    w_state_nxt = S_LOAD;
                    w_owner_nxt = w_pick;
                    w_grant_nxt = {{(NREQ-1){1'b0}}, 1'b1} << w_pick;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_count_nxt = '0;
                    w_grant_nxt = '0;
                end else begin
                    w_state_nxt = S_RUN;
                    w_count_nxt = w_load;
                end
            end
            S_RUN: begin
                // abort wins over reaching zero in the same cycle
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_count_nxt = '0;
                    w_grant_nxt = '0;
                end else if (r_count != '0) begin
                    w_count_nxt = r_count - 1'b1;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
                w_ptr_nxt   = (r_owner == IW'(NREQ-1)) ? '0 : r_owner + 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_grant <= '0;
            r_owner <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_grant <= w_grant_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    assign grant = r_grant;
    assign count = r_count;
    assign busy  = (r_state != S_IDLE);
    assign done  = (r_state == S_DONE) ? r_grant : '0;

endmodule
`default_nettype wire

// File: tb/tb_shared_timer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_shared_timer_arbiter
// Brief    : Scoreboard bench: expected done pulses queued, checked by monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shared_timer_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] load_val;
    logic        abort;
    logic [3:0]  grant;
    logic        busy;
    logic [7:0]  count;
    logic [3:0]  done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int e0;

    typedef struct {
        logic [3:0] d;
        int         at_edge;
    } exp_t;
    exp_t sb[$];

    shared_timer_arbiter #(.NREQ(4), .WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .load_val (load_val),
        .abort    (abort),
        .grant    (grant),
        .busy     (busy),
        .count    (count),
        .done     (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // Monitor: every done pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (!$onehot0(grant)) begin
                errors++;
                $display("FAIL grant_onehot: grant=%b at edge %0d", grant, cyc);
            end
            if (done != 4'b0000) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected: done=%b at edge %0d, none expected", done, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (done !== e.d || cyc != e.at_edge || (done & ~grant) != 4'b0000) begin
                        errors++;
                        $display("FAIL done_pulse: got done=%b grant=%b edge %0d, want done=%b edge %0d",
                                 done, grant, cyc, e.d, e.at_edge);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] d, input int at_edge);
        exp_t e;
        e.d = d;
        e.at_edge = at_edge;
        sb.push_back(e);
    endtask

    task automatic wait_sb(input int maxc);
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) return;
        end
        checks++;
        errors++;
        $display("FAIL sb_timeout: %0d done pulses outstanding, want 0", sb.size());
        sb.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = '0; abort = 1'b0; load_val = '0;
        repeat (2) @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_done",  done,  0);
        chk("rst_busy",  busy,  0);
        chk("rst_count", count, 0);
        rst = 1'b0;

        // 1: single request, L=3
        @(negedge clk);
        load_val = 32'h0000_0003; req = 4'b0001; e0 = cyc + 1;
        push(4'b0001, e0 + 5);
        @(negedge clk);
        chk("t1_grant", grant, 4'b0001);
        chk("t1_busy",  busy,  1);
        req = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t1_count", count, 3 - k);
        end
        wait_sb(10);
        @(negedge clk);
        chk("t1_idle_busy",  busy,  0);
        chk("t1_idle_grant", grant, 0);

        // 2: requesters 0 and 2 together, held
        do_reset();
        load_val = 32'h0001_0002; req = 4'b0101; e0 = cyc + 1;
        push(4'b0001, e0 + 4);
        push(4'b0100, e0 + 9);
        wait_sb(30);
        req = '0;
        repeat (2) @(negedge clk);

        // 3: all four held, L=0, rotation
        do_reset();
        load_val = '0; req = 4'b1111; e0 = cyc + 1;
        push(4'b0001, e0 + 2);
        push(4'b0010, e0 + 6);
        push(4'b0100, e0 + 10);
        push(4'b1000, e0 + 14);
        push(4'b0001, e0 + 18);
        wait_sb(40);
        req = '0;
        repeat (3) @(negedge clk);

        // 4: L=0 on requester 1, no wrap
        do_reset();
        load_val = 32'h0305_0007; req = 4'b0010; e0 = cyc + 1;
        push(4'b0010, e0 + 2);
        @(negedge clk);
        chk("t4_grant", grant, 4'b0010);
        req = '0;
        @(negedge clk);
        chk("t4_count_e1", count, 0);
        wait_sb(10);
        chk("t4_count_e2", count, 0);
        @(negedge clk);
        chk("t4_count_e3", count, 0);
        chk("t4_busy_e3",  busy,  0);

        // 5: abort at count=6; pointer is 2 here, so 0011 must pick 0
        load_val = 32'h0000_000A; req = 4'b0001;
        @(negedge clk);
        chk("t5_grant", grant, 4'b0001);
        req = '0;
        repeat (5) @(negedge clk);
        chk("t5_count6", count, 6);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t5_ab_busy",  busy,  0);
        chk("t5_ab_grant", grant, 0);
        chk("t5_ab_count", count, 0);
        chk("t5_ab_done",  done,  0);
        @(negedge clk);
        load_val = 32'h0000_0001; req = 4'b0011; e0 = cyc + 1;
        push(4'b0001, e0 + 3);
        @(negedge clk);
        chk("t5_regrant", grant, 4'b0001);
        req = '0;
        wait_sb(10);
        repeat (2) @(negedge clk);

        // 6: async reset mid-RUN, then pointer back at 0
        load_val = 32'h0000_0800; req = 4'b0010;
        @(negedge clk);
        chk("t6_grant", grant, 4'b0010);
        req = '0;
        repeat (5) @(negedge clk);
        chk("t6_count4", count, 4);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_grant", grant, 0);
        chk("t6_rst_count", count, 0);
        chk("t6_rst_busy",  busy,  0);
        chk("t6_rst_done",  done,  0);
        @(negedge clk);
        rst = 1'b0;
        load_val = 32'h0000_0302; req = 4'b0011; e0 = cyc + 1;
        push(4'b0001, e0 + 4);
        @(negedge clk);
        chk("t6_first_grant", grant, 4'b0001);
        req = '0;
        wait_sb(12);
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
